// File: rtl/cheriot_dv_pkg.sv
// cheriot_dv_pkg: shared types and constants for the DII instruction feeder
package cheriot_dv_pkg;
  localparam int DiiAddrWidth = 32;
  localparam logic [31:0] DiiNopInsn = 32'h1;
  typedef struct packed {
    logic [DiiAddrWidth-1:2] addr;
    logic [2:0]              age;
  } dii_fetch_t;
endpackage

// File: rtl/dii_req_fifo.sv
// dii_req_fifo: in-order circular queue of granted fetches with per-entry ageing
module dii_req_fifo
  import cheriot_dv_pkg::*;
#(
  parameter int Depth   = 2,
  parameter int Latency = 1,
  localparam int CW     = $clog2(Depth + 1),
  localparam int PW     = Depth > 1 ? $clog2(Depth) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    push,
  input  logic                    pop,
  input  logic [DiiAddrWidth-1:2] push_addr,
  output logic                    full,
  output logic                    empty,
  output logic                    head_ready,
  output logic [DiiAddrWidth-1:2] head,
  output logic [CW-1:0]           count
);
  dii_fetch_t      mem [Depth];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < Depth; i++)
        if (mem[i].age != 3'(Latency)) mem[i].age <= mem[i].age + 3'd1;
      // a fresh push overrides the ageing of the slot it lands in
      if (push) begin
        mem[wptr] <= '{addr: push_addr, age: 3'd0};
        wptr      <= (wptr == PW'(Depth - 1)) ? '0 : wptr + 1'b1;
      end
      if (pop) rptr <= (rptr == PW'(Depth - 1)) ? '0 : rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  assign full       = count == CW'(Depth);
  assign empty      = count == '0;
  assign head       = mem[rptr].addr;
  assign head_ready = !empty && mem[rptr].age == 3'(Latency - 1);
`ifndef SYNTHESIS
  a_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni) push |-> (!full || pop));
`endif
endmodule

// File: rtl/dii_instr_feeder.sv
// dii_instr_feeder: answers core fetches in order, after a fixed latency, with
// the current DII stream word and acknowledges each consumed word.
module dii_instr_feeder
  import cheriot_dv_pkg::*;
#(
  parameter int MaxOutstanding = 2,
  parameter int RespLatency    = 1,
  parameter int AddrWidth      = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 instr_req_i,
  input  logic [AddrWidth-1:0] instr_addr_i,
  output logic                 instr_gnt_o,
  output logic                 instr_rvalid_o,
  output logic [31:0]          instr_rdata_o,
  output logic                 instr_err_o,
  input  logic [31:0]          dii_insn_i,
  output logic [31:0]          dii_pc_o,
  output logic                 dii_ack_o
);
  localparam int CW = $clog2(MaxOutstanding + 1);
  logic                    full;
  logic                    empty;
  logic                    pop;
  logic [DiiAddrWidth-1:2] head;
  logic [CW-1:0]           count;
  logic [31:0]             pc_q;
  logic                    unused_addr;
  assign unused_addr = ^instr_addr_i[1:0];
  // gating with rst_ni keeps gnt low while reset is held, even with req high
  assign instr_gnt_o = rst_ni && instr_req_i && (!full || pop);
  dii_req_fifo #(
    .Depth  (MaxOutstanding),
    .Latency(RespLatency)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push      (instr_gnt_o),
    .pop       (pop),
    .push_addr ((DiiAddrWidth - 2)'(instr_addr_i[AddrWidth-1:2])),
    .full      (full),
    .empty     (empty),
    .head_ready(pop),
    .head      (head),
    .count     (count)
  );
  assign instr_rvalid_o = pop;
  assign dii_ack_o      = pop;
  assign instr_err_o    = 1'b0;
  assign instr_rdata_o  = pop ? dii_insn_i : '0;
  assign dii_pc_o       = pop ? {head, 2'b00} : pc_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pc_q <= '0;
    else if (pop) pc_q <= {head, 2'b00};
  end
`ifndef SYNTHESIS
  a_rvalid_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni) instr_rvalid_o |-> !empty);
  a_ack_is_rvalid:   assert property (@(posedge clk_i) disable iff (!rst_ni) dii_ack_o == instr_rvalid_o);
  a_count_bound:     assert property (@(posedge clk_i) disable iff (!rst_ni) count <= CW'(MaxOutstanding));
`endif
endmodule

// File: tb/tb_dii_instr_feeder.sv
// tb_dii_instr_feeder: two feeders (latency 1 and 4) driven in lockstep and
// checked every cycle against a queue-of-grant-times reference model.
module tb_dii_instr_feeder;
  import cheriot_dv_pkg::*;
  localparam int MaxO = 2;
  typedef struct {
    logic [31:0] pc;
    int          t;
  } ent_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] insn = '0;
  logic [1:0]  gnt, rv, ack, err;
  logic [31:0] rdata [2];
  logic [31:0] pc [2];
  int          lat [2] = '{1, 4};
  ent_t        mq [2][$];
  logic [1:0]  e_gnt, e_rv;
  logic [31:0] e_rdata [2];
  logic [31:0] e_pc [2];
  logic [31:0] last_pc [2] = '{32'h0, 32'h0};
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  always #5 clk = ~clk;
  dii_instr_feeder #(.MaxOutstanding(MaxO), .RespLatency(1), .AddrWidth(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[0]), .instr_rvalid_o(rv[0]), .instr_rdata_o(rdata[0]), .instr_err_o(err[0]),
    .dii_insn_i(insn), .dii_pc_o(pc[0]), .dii_ack_o(ack[0]));
  dii_instr_feeder #(.MaxOutstanding(MaxO), .RespLatency(4), .AddrWidth(32)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .instr_req_i(req), .instr_addr_i(addr),
    .instr_gnt_o(gnt[1]), .instr_rvalid_o(rv[1]), .instr_rdata_o(rdata[1]), .instr_err_o(err[1]),
    .dii_insn_i(insn), .dii_pc_o(pc[1]), .dii_ack_o(ack[1]));
  // a fetch granted at cycle t is answered at cycle t+lat, in grant order
  task automatic model_eval();
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        mq[k].delete();
        last_pc[k] = '0;
      end
      e_rv[k]    = rst_n && mq[k].size() > 0 && mq[k][0].t + lat[k] == cyc;
      e_gnt[k]   = rst_n && req && (mq[k].size() < MaxO || e_rv[k]);
      e_rdata[k] = e_rv[k] ? insn : 32'h0;
      e_pc[k]    = e_rv[k] ? mq[k][0].pc : last_pc[k];
    end
  endtask
  task automatic tick();
    @(posedge clk);
    if (rst_n)
      for (int k = 0; k < 2; k++) begin
        if (e_rv[k]) begin
          void'(mq[k].pop_front());
          last_pc[k] = e_pc[k];
        end
        if (e_gnt[k]) mq[k].push_back('{addr & ~32'h3, cyc});
      end
    cyc++;
    @(negedge clk);
  endtask
  task automatic idle(int n);
    req = 1'b0;
    for (int i = 0; i < n; i++) begin
      #1 model_eval();
      tick();
    end
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    req   = 1'b1;
    addr  = 32'h1234_5678;
    insn  = 32'hdead_beef;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1 model_eval();
      tests++;
      if ({gnt, rv, ack, err} !== 8'h0 || pc[0] !== 32'h0 || pc[1] !== 32'h0 || rdata[0] !== 32'h0) begin
        fails++;
        $display("FAIL reset cyc %0d: gnt=%b rv=%b ack=%b err=%b pc0=%h pc1=%h rdata0=%h, want all 0", i, gnt, rv, ack, err, pc[0], pc[1], rdata[0]);
      end
      tick();
    end
    rst_n = 1'b1;
    req   = 1'b0;
    idle(2);
  endtask
  task automatic test_single_fetch();
    req  = 1'b1;
    addr = 32'h8000_0002;
    insn = 32'h0000_0013;
    #1 model_eval();
    tests++;
    if (gnt[0] !== 1'b1) begin
      fails++;
      $display("FAIL single_gnt: gnt=%b, want 1", gnt[0]);
    end
    tick();
    req = 1'b0;
    #1 model_eval();
    tests++;
    if (rv[0] !== 1'b1 || ack[0] !== 1'b1 || rdata[0] !== 32'h13 || pc[0] !== 32'h8000_0000) begin
      fails++;
      $display("FAIL single_resp: rv=%b ack=%b rdata=%h pc=%h, want 1 1 00000013 80000000", rv[0], ack[0], rdata[0], pc[0]);
    end
    tick();
    #1;
    tests++;
    if (rv[0] !== 1'b0 || ack[0] !== 1'b0 || rdata[0] !== 32'h0 || pc[0] !== 32'h8000_0000) begin
      fails++;
      $display("FAIL single_after: rv=%b ack=%b rdata=%h pc=%h, want 0 0 00000000 80000000 (held)", rv[0], ack[0], rdata[0], pc[0]);
    end
    idle(6);
  endtask
  task automatic test_streaming();
    logic [31:0] words [8];
    logic [31:0] got [$];
    logic [31:0] pcs [$];
    int          i = 0;
    int          j = 0;
    int          grants8 = 0;
    for (int w = 0; w < 8; w++) words[w] = $urandom;
    insn = words[0];
    for (int c = 0; c < 10; c++) begin
      req  = i < 8;
      addr = 32'(i * 4);
      #1 model_eval();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k]} !== {e_gnt[k], e_rv[k], e_rv[k], 1'b0, e_rdata[k], e_pc[k]}) begin
          fails++;
          $display("FAIL stream dut%0d cyc %0d: got gnt/rv/ack/err=%b%b%b%b rdata=%h pc=%h, want %b%b%b0 rdata=%h pc=%h", k, cyc, gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k], e_gnt[k], e_rv[k], e_rv[k], e_rdata[k], e_pc[k]);
        end
      end
      if (rv[0]) begin
        got.push_back(rdata[0]);
        pcs.push_back(pc[0]);
      end
      if (gnt[0] && c < 8) grants8++;
      if (gnt[0]) i++;
      if (ack[0]) j++;
      tick();
      insn = words[j < 8 ? j : 7];
    end
    tests++;
    if (grants8 != 8 || got.size() != 8) begin
      fails++;
      $display("FAIL stream_count: grants=%0d responses=%0d, want 8 8", grants8, got.size());
    end
    for (int w = 0; w < 8 && w < got.size(); w++) begin
      tests++;
      if (got[w] !== words[w] || pcs[w] !== 32'(w * 4)) begin
        fails++;
        $display("FAIL stream_word%0d: rdata=%h pc=%h, want %h %h", w, got[w], pcs[w], words[w], 32'(w * 4));
      end
    end
    idle(6);
  endtask
  task automatic test_backpressure();
    logic [7:0] pat = '0;
    for (int c = 0; c < 8; c++) begin
      req  = 1'b1;
      addr = 32'h100 + 32'(c * 4);
      insn = $urandom;
      #1 model_eval();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k]} !== {e_gnt[k], e_rv[k], e_rv[k], 1'b0, e_rdata[k], e_pc[k]}) begin
          fails++;
          $display("FAIL backpressure dut%0d cyc %0d: got gnt/rv/ack/err=%b%b%b%b rdata=%h pc=%h, want %b%b%b0 rdata=%h pc=%h", k, cyc, gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k], e_gnt[k], e_rv[k], e_rv[k], e_rdata[k], e_pc[k]);
        end
      end
      pat = {pat[6:0], gnt[1]};
      tick();
    end
    tests++;
    if (pat !== 8'b1100_1100) begin
      fails++;
      $display("FAIL backpressure_pattern: gnt=%b, want 11001100", pat);
    end
    idle(8);
  endtask
  task automatic test_reset_midflight();
    logic        b_rv_seen = 1'b0;
    logic [31:0] w;
    for (int c = 0; c < 2; c++) begin
      req  = 1'b1;
      addr = 32'h200 + 32'(c * 4);
      #1 model_eval();
      tick();
    end
    req   = 1'b0;
    rst_n = 1'b0;
    #1 model_eval();
    tests++;
    if ({gnt, rv, ack} !== 6'h0 || pc[0] !== 32'h0 || pc[1] !== 32'h0) begin
      fails++;
      $display("FAIL midreset_clear: gnt=%b rv=%b ack=%b pc0=%h pc1=%h, want all 0", gnt, rv, ack, pc[0], pc[1]);
    end
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1 model_eval();
      if (rv[1] || ack[1] || rv[0]) b_rv_seen = 1'b1;
      tick();
    end
    tests++;
    if (b_rv_seen !== 1'b0) begin
      fails++;
      $display("FAIL midreset_dropped: saw rvalid/ack=1, want 0 for dropped fetches");
    end
    w    = $urandom;
    insn = w;
    req  = 1'b1;
    addr = 32'h300;
    #1 model_eval();
    tick();
    req = 1'b0;
    #1 model_eval();
    tests++;
    if (rv[0] !== 1'b1 || rdata[0] !== w || pc[0] !== 32'h300) begin
      fails++;
      $display("FAIL midreset_first: rv=%b rdata=%h pc=%h, want 1 %h 00000300", rv[0], rdata[0], pc[0], w);
    end
    tick();
    idle(6);
  endtask
  task automatic test_end_of_stream();
    insn = DiiNopInsn;
    for (int c = 0; c < 30; c++) begin
      req  = $urandom_range(0, 3) != 0;
      addr = $urandom;
      #1 model_eval();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k]} !== {e_gnt[k], e_rv[k], e_rv[k], 1'b0, e_rdata[k], e_pc[k]}
            || (rv[k] && rdata[k] !== 32'h1) || $isunknown({gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k]})) begin
          fails++;
          $display("FAIL eos dut%0d cyc %0d: got gnt/rv/ack/err=%b%b%b%b rdata=%h pc=%h, want %b%b%b0 rdata=%h pc=%h", k, cyc, gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k], e_gnt[k], e_rv[k], e_rv[k], e_rdata[k], e_pc[k]);
        end
      end
      tick();
    end
    idle(6);
  endtask
  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst_n = $urandom_range(0, 99) != 0;
      req   = $urandom_range(0, 9) < 7;
      addr  = $urandom;
      insn  = $urandom;
      #1 model_eval();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if ({gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k]} !== {e_gnt[k], e_rv[k], e_rv[k], 1'b0, e_rdata[k], e_pc[k]}) begin
          fails++;
          $display("FAIL random dut%0d cyc %0d: got gnt/rv/ack/err=%b%b%b%b rdata=%h pc=%h, want %b%b%b0 rdata=%h pc=%h", k, cyc, gnt[k], rv[k], ack[k], err[k], rdata[k], pc[k], e_gnt[k], e_rv[k], e_rv[k], e_rdata[k], e_pc[k]);
        end
      end
      tick();
    end
    rst_n = 1'b1;
    idle(6);
  endtask
  initial begin
    test_reset();
    test_single_fetch();
    test_streaming();
    test_backpressure();
    test_reset_midflight();
    test_end_of_stream();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
